if_stage: RTL
=============

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage: PC register, next-PC select, IF/ID pipeline register.
//  Sits directly upstream of the hazard unit and ID stage.
//  Consumes the hazard unit's PC_Wr_en / IF_ID_Wr_en / IF_ID_flush.
//  Produces the IF/ID instruction and PC+4 that the hazard unit and decoder read.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset (word aligned)
//  NOP_INSTR  32'h0000_0000  instruction injected into IF/ID on flush/reset (sll $0,$0,0)
// PORTS
//  clk              in   1   single clock, rising edge
//  reset            in   1   asynchronous, active-low reset
//  PC_Wr_en         in   1   from hazard unit; 0 = hold PC (load-use stall)
//  IF_ID_Wr_en      in   1   from hazard unit; 0 = hold IF/ID register
//  IF_ID_flush      in   1   from hazard unit; 1 = replace IF/ID contents with bubble
//  Branch_taken     in   1   ID/EX branch resolved taken (EX stage)
//  Branch_target    in   32  branch target from EX
//  Jump             in   1   j/jal decoded in ID
//  Jump_target      in   32  {PC+4[31:28], imm26, 2'b00} from ID
//  JumpReg          in   1   jr/jalr decoded in ID
//  JumpReg_target   in   32  forwarded rs value from ID
//  IM_addr          out  32  instruction-memory byte address (= PC), combinational read
//  IM_data          in   32  instruction returned same cycle
//  PC               out  32  current PC register
//  IF_ID_Instruction out 32  latched instruction (OpCode/Funct/rs/rt source for hazard unit)
//  IF_ID_PC_plus4   out  32  latched PC+4 of that instruction
//  IF_ID_valid      out  1   1 = IF/ID holds a real fetched instruction
// BEHAVIOUR
//  Reset (reset=0, async):
//   PC=RESET_PC; IF_ID_Instruction=NOP_INSTR; IF_ID_PC_plus4=0; IF_ID_valid=0.
//  Fetch: IM_addr=PC each cycle; PC+4 computed mod 2^32 (0xFFFF_FFFC wraps to 0).
//  Next-PC priority, highest first:
//   1. Branch_taken: Branch_target.
//      PC loads even when PC_Wr_en=0 -- a taken branch overrides a load-use stall.
//   2. JumpReg & IF_ID_valid: {JumpReg_target[31:2],2'b00}.
//   3. Jump & IF_ID_valid: Jump_target.
//   4. otherwise: PC+4.
//   Jump/JumpReg ignored when Branch_taken=1; the ID instruction is wrong-path.
//  PC update: PC<=next_PC when (PC_Wr_en | Branch_taken), else hold.
//  IF/ID register, priority:
//   - IF_ID_flush=1: Instruction<=NOP_INSTR, PC_plus4<=0, valid<=0.
//     Flush wins over IF_ID_Wr_en=0.
//   - else IF_ID_Wr_en=1: Instruction<=IM_data, PC_plus4<=PC+4, valid<=1.
//   - else hold all three.
//  Latency: instruction at PC visible on IF_ID_* one clock after PC presented.
//  Taken jump costs 1 bubble; taken branch costs 2 (IF/ID + ID/EX flushed by hazard unit).
//  First edge after reset release: IF/ID captures instruction at RESET_PC.
//  Reset asserted mid-stream: all state returns to reset values immediately; no partial update.
//  Misaligned Branch_target/Jump_target used as-is; alignment is the producer's job.
// CONFIGURATION
//  PERF_CNT_EN defined:
//   - adds outputs Stall_cnt[31:0] and Flush_cnt[31:0], both reset to 0.
//   - Stall_cnt +1 on each cycle with IF_ID_Wr_en=0 & IF_ID_flush=0.
//   - Flush_cnt +1 on each cycle with IF_ID_flush=1.
//   - both saturate at 32'hFFFF_FFFF.
//  PERF_CNT_EN undefined: counter ports and logic absent; all other behaviour identical.
// TESTING
//  1. Reset then 4 clocks, enables=1, IM returns 0x2000_000n:
//     -> PC 0,4,8,C,10; IF_ID_valid=1 from 1st edge; IF_ID_PC_plus4=4,8,C,10.
//  2. PC_Wr_en=IF_ID_Wr_en=0 for 2 cycles at PC=8:
//     -> PC stays 8; IF_ID holds; resumes to C after release.
//  3. Jump=1, Jump_target=0x100, IF_ID_flush=1, IF_ID_valid=1:
//     -> next PC=0x100; IF_ID=NOP_INSTR, valid=0.
//  4. Branch_taken=1 (target 0x40) with Jump=1 (target 0x100) and PC_Wr_en=0:
//     -> PC=0x40; IF_ID flushed.
//  5. JumpReg=1, target 0x0000_0203 -> PC=0x200.
//     Separately, RESET_PC=0xFFFF_FFFC, 1 clock -> PC wraps to 0.
//  6. Assert reset mid-run at PC=0x24 between edges:
//     -> PC=RESET_PC, valid=0 immediately.
//     With PERF_CNT_EN: 3 stalls + 2 flushes -> Stall_cnt=3, Flush_cnt=2.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select and IF/ID pipeline register.
// Optional performance counters (Stall_cnt / Flush_cnt) are enabled by defining PERF_CNT_EN.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PC_Wr_en,
    input  logic        IF_ID_Wr_en,
    input  logic        IF_ID_flush,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_target,
    input  logic        Jump,
    input  logic [31:0] Jump_target,
    input  logic        JumpReg,
    input  logic [31:0] JumpReg_target,
    output logic [31:0] IM_addr,
    input  logic [31:0] IM_data,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PC_plus4,
    output logic        IF_ID_valid
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] Stall_cnt,
    output logic [31:0] Flush_cnt
`endif
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    assign pc_plus4 = pc_q + 32'd4;

    // A taken branch comes from EX, so the jump decoded in ID behind it is wrong-path.
    always_comb begin
        next_pc = pc_plus4;
        if (Branch_taken) begin
            next_pc = Branch_target;
        end else if (JumpReg && valid_q) begin
            next_pc = JumpReg_target & ~32'd3;
        end else if (Jump && valid_q) begin
            next_pc = Jump_target;
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (PC_Wr_en || Branch_taken) begin
            pc_d = next_pc;
        end
    end

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (IF_ID_flush) begin
            instr_d = NOP_INSTR;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
        end else if (IF_ID_Wr_en) begin
            instr_d = IM_data;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign IM_addr           = pc_q;
    assign PC                = pc_q;
    assign IF_ID_Instruction = instr_q;
    assign IF_ID_PC_plus4    = pc4_q;
    assign IF_ID_valid       = valid_q;

`ifdef PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!IF_ID_Wr_en && !IF_ID_flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (IF_ID_flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign Stall_cnt = stall_cnt_q;
    assign Flush_cnt = flush_cnt_q;
`endif

endmodule
